// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in, stall/bubble/flush strobes out.
// The master modport is the pipeline side, the slave modport is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic [4:0]       i_ex_rd;
  logic             i_ex_is_load;
  logic             i_ex_mdu_start;
  logic             i_mdu_done;
  logic             i_mem_req;
  logic             i_mem_ready;
  logic             i_ex_redirect;
  logic             o_stall_if;
  logic             o_stall_id;
  logic             o_stall_ex;
  logic             o_stall_mem;
  logic             o_bubble_ex;
  logic             o_bubble_mem;
  logic             o_bubble_wb;
  logic             o_flush_if_id;
  logic             o_flush_id_ex;
  logic             o_err;
  logic [CNT_W-1:0] o_stall_cycles;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rd, i_ex_is_load,
           i_ex_mdu_start, i_mdu_done, i_mem_req, i_mem_ready, i_ex_redirect,
    input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_bubble_ex, o_bubble_mem,
           o_bubble_wb, o_flush_if_id, o_flush_id_ex, o_err, o_stall_cycles, o_flush_cnt
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rd, i_ex_is_load,
           i_ex_mdu_start, i_mdu_done, i_mem_req, i_mem_ready, i_ex_redirect,
    output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_bubble_ex, o_bubble_mem,
           o_bubble_wb, o_flush_if_id, o_flush_id_ex, o_err, o_stall_cycles, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencer for the 5-stage core.
// Handles load-use, multi-cycle MDU ops, data-memory wait states and EX redirects.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating perf counters
// (o_stall_cycles, o_flush_cnt); when undefined both ports read as zero.
module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_ctrl_if.slave hz
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_MDU = 2'd1,
    S_MEM = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            ret_mdu_r;
  logic            done_lat_r;
  logic            err_r;
  logic [WD_W-1:0] wd_r;

  logic mem_wait_s;
  logic mdu_pend_s;
  logic wd_expire_s;
  logic timeout_s;
  logic load_use_s;

  logic stall_if_s;
  logic stall_id_s;
  logic stall_ex_s;
  logic stall_mem_s;
  logic bubble_ex_s;
  logic bubble_mem_s;
  logic bubble_wb_s;
  logic flush_s;

  // Hazard detection terms shared by next-state and output logic.
  always_comb begin
    mem_wait_s  = hz.i_mem_req & ~hz.i_mem_ready;
    // An MDU op is still outstanding if one is running or just starting and not done now.
    mdu_pend_s  = ((state_r == S_MDU) | ((state_r == S_RUN) & hz.i_ex_mdu_start)) & ~hz.i_mdu_done;
    wd_expire_s = (wd_r >= WD_W'(MDU_TIMEOUT - 1));
    timeout_s   = (state_r == S_MDU) & ~mem_wait_s & ~hz.i_mdu_done & wd_expire_s;
    load_use_s  = hz.i_ex_is_load & (hz.i_ex_rd != 5'd0) &
                  ((hz.i_id_use_rs1 & (hz.i_id_rs1 == hz.i_ex_rd)) |
                   (hz.i_id_use_rs2 & (hz.i_id_rs2 == hz.i_ex_rd)));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; memory wait outranks everything else.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_RUN: begin
        if (mem_wait_s) begin
          next_state_s = S_MEM;
        end else if (hz.i_ex_mdu_start & ~hz.i_mdu_done) begin
          next_state_s = S_MDU;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_MDU: begin
        if (mem_wait_s) begin
          next_state_s = S_MEM;
        end else if (hz.i_mdu_done | wd_expire_s) begin
          next_state_s = S_RUN;
        end else begin
          next_state_s = S_MDU;
        end
      end
      S_MEM: begin
        if (mem_wait_s) begin
          next_state_s = S_MEM;
        end else if (ret_mdu_r & ~(done_lat_r | hz.i_mdu_done)) begin
          next_state_s = S_MDU;
        end else begin
          next_state_s = S_RUN;
        end
      end
      default: begin
        next_state_s = S_RUN;
      end
    endcase
  end

  // Return-state and latched-done bookkeeping for memory waits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ret_mdu_r  <= 1'b0;
      done_lat_r <= 1'b0;
    end else begin
      if (mem_wait_s && (state_r != S_MEM)) begin
        ret_mdu_r <= mdu_pend_s;
      end else begin
        ret_mdu_r <= ret_mdu_r;
      end
      // A done pulse seen while parked in S_MEM must not be lost.
      if ((state_r == S_MEM) && mem_wait_s) begin
        done_lat_r <= done_lat_r | hz.i_mdu_done;
      end else begin
        done_lat_r <= 1'b0;
      end
    end
  end

  // MDU watchdog counter and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_r  <= '0;
      err_r <= 1'b0;
    end else begin
      if (next_state_s == S_RUN) begin
        wd_r <= '0;
      end else if ((state_r == S_MDU) && (wd_r != WD_W'(MDU_TIMEOUT))) begin
        wd_r <= wd_r + WD_W'(1);
      end else begin
        wd_r <= wd_r;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Strobe generation from state and inputs, forced quiet during reset.
  always_comb begin
    stall_if_s   = 1'b0;
    stall_id_s   = 1'b0;
    stall_ex_s   = 1'b0;
    stall_mem_s  = 1'b0;
    bubble_ex_s  = 1'b0;
    bubble_mem_s = 1'b0;
    bubble_wb_s  = 1'b0;
    flush_s      = 1'b0;
    if (!i_rst) begin
      if (mem_wait_s) begin
        stall_if_s  = 1'b1;
        stall_id_s  = 1'b1;
        stall_ex_s  = 1'b1;
        stall_mem_s = 1'b1;
        bubble_wb_s = 1'b1;
      end else begin
        case (state_r)
          S_MDU: begin
            if (!hz.i_mdu_done && !wd_expire_s) begin
              stall_if_s   = 1'b1;
              stall_id_s   = 1'b1;
              stall_ex_s   = 1'b1;
              bubble_mem_s = 1'b1;
            end else begin
              stall_if_s   = 1'b0;
            end
          end
          S_RUN: begin
            if (hz.i_ex_mdu_start && !hz.i_mdu_done) begin
              stall_if_s   = 1'b1;
              stall_id_s   = 1'b1;
              stall_ex_s   = 1'b1;
              bubble_mem_s = 1'b1;
            end else if (load_use_s && !hz.i_ex_redirect) begin
              // Single-cycle hold; forwarding covers the following cycle.
              stall_if_s  = 1'b1;
              stall_id_s  = 1'b1;
              bubble_ex_s = 1'b1;
            end else begin
              stall_if_s  = 1'b0;
            end
          end
          S_MEM: begin
            stall_if_s = 1'b0;
          end
          default: begin
            stall_if_s = 1'b0;
          end
        endcase
      end
      // A stalled EX instruction re-asserts its redirect once released.
      if (hz.i_ex_redirect && !stall_ex_s) begin
        flush_s = 1'b1;
      end else begin
        flush_s = 1'b0;
      end
    end else begin
      flush_s = 1'b0;
    end
  end

  assign hz.o_stall_if    = stall_if_s;
  assign hz.o_stall_id    = stall_id_s;
  assign hz.o_stall_ex    = stall_ex_s;
  assign hz.o_stall_mem   = stall_mem_s;
  assign hz.o_bubble_ex   = bubble_ex_s;
  assign hz.o_bubble_mem  = bubble_mem_s;
  assign hz.o_bubble_wb   = bubble_wb_s;
  assign hz.o_flush_if_id = flush_s;
  assign hz.o_flush_id_ex = flush_s;
  assign hz.o_err         = err_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating perf counters: stalled-PC cycles and redirect flushes taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_if_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.o_stall_cycles = stall_cnt_r;
  assign hz.o_flush_cnt    = flush_cnt_r;
`else
  assign hz.o_stall_cycles = {CNT_W{1'b0}};
  assign hz.o_flush_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MDU_TO = 64;
  localparam int M_RUN  = 0;
  localparam int M_MDU  = 1;
  localparam int M_MEM  = 2;

  logic i_clk;
  logic i_rst;

  hazard_ctrl_if #(.CNT_W(32)) hz_bus ();

  hazard_ctrl #(.MDU_TIMEOUT(MDU_TO), .CNT_W(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .hz    (hz_bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_mode = M_RUN;
  int m_wd   = 0;
  bit m_err  = 1'b0;
  bit m_ret  = 1'b0;
  bit m_dl   = 1'b0;
  int m_sc   = 0;
  int m_fc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobes {stall_if,stall_id,stall_ex,stall_mem,bubble_ex,bubble_mem,bubble_wb,flush_if_id,flush_id_ex}.
  function automatic logic [8:0] model_strobes();
    bit mw, lu, mdu_hold, st_ex;
    logic [8:0] r;
    r = 9'd0;
    if (i_rst) return 9'd0;
    mw = hz_bus.i_mem_req && !hz_bus.i_mem_ready;
    lu = hz_bus.i_ex_is_load && (hz_bus.i_ex_rd != 5'd0) &&
         ((hz_bus.i_id_use_rs1 && hz_bus.i_id_rs1 == hz_bus.i_ex_rd) ||
          (hz_bus.i_id_use_rs2 && hz_bus.i_id_rs2 == hz_bus.i_ex_rd));
    mdu_hold = ((m_mode == M_MDU) && !hz_bus.i_mdu_done && (m_wd < MDU_TO - 1)) ||
               ((m_mode == M_RUN) && hz_bus.i_ex_mdu_start && !hz_bus.i_mdu_done);
    if (mw)                                             r = 9'b111100100;
    else if (mdu_hold)                                  r = 9'b111001000;
    else if (m_mode == M_RUN && lu && !hz_bus.i_ex_redirect) r = 9'b110010000;
    st_ex = r[6];
    if (hz_bus.i_ex_redirect && !st_ex) r[1:0] = 2'b11;
    return r;
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_clock(input logic [8:0] st);
    bit mw, keep_dl, dn;
    int nm;
    if (i_rst) begin
      m_mode = M_RUN; m_wd = 0; m_err = 1'b0; m_ret = 1'b0; m_dl = 1'b0; m_sc = 0; m_fc = 0;
      return;
    end
    mw = hz_bus.i_mem_req && !hz_bus.i_mem_ready;
    dn = hz_bus.i_mdu_done;
    if (st[8]) m_sc++;
    if (st[1]) m_fc++;
    keep_dl = (m_mode == M_MEM) && mw;
    nm = m_mode;
    case (m_mode)
      M_RUN: begin
        if (mw) begin m_ret = hz_bus.i_ex_mdu_start && !dn; nm = M_MEM; end
        else if (hz_bus.i_ex_mdu_start && !dn) nm = M_MDU;
        else nm = M_RUN;
      end
      M_MDU: begin
        if (mw) begin m_ret = !dn; nm = M_MEM; end
        else if (dn) nm = M_RUN;
        else if (m_wd >= MDU_TO - 1) begin m_err = 1'b1; nm = M_RUN; end
        else nm = M_MDU;
      end
      default: begin
        if (mw) begin m_dl = m_dl || dn; nm = M_MEM; end
        else nm = (m_ret && !(m_dl || dn)) ? M_MDU : M_RUN;
      end
    endcase
    if (!keep_dl) m_dl = 1'b0;
    if (nm == M_RUN) m_wd = 0;
    else if (m_mode == M_MDU && m_wd < MDU_TO) m_wd++;
    m_mode = nm;
  endtask

  // One clock: inputs already applied after the falling edge.
  task automatic step();
    logic [8:0] exp_s, got_s;
    #1;
    exp_s = model_strobes();
    got_s = {hz_bus.o_stall_if, hz_bus.o_stall_id, hz_bus.o_stall_ex, hz_bus.o_stall_mem,
             hz_bus.o_bubble_ex, hz_bus.o_bubble_mem, hz_bus.o_bubble_wb,
             hz_bus.o_flush_if_id, hz_bus.o_flush_id_ex};
    check_val("strobes", {55'd0, got_s}, {55'd0, exp_s});
    @(posedge i_clk);
    model_clock(exp_s);
    #1;
    check_val("err", {63'd0, hz_bus.o_err}, {63'd0, m_err});
`ifdef HAZARD_PERF_CNT_EN
    check_val("stall_cycles", {32'd0, hz_bus.o_stall_cycles}, 64'(m_sc));
    check_val("flush_cnt", {32'd0, hz_bus.o_flush_cnt}, 64'(m_fc));
`else
    check_val("stall_cycles", {32'd0, hz_bus.o_stall_cycles}, 64'd0);
    check_val("flush_cnt", {32'd0, hz_bus.o_flush_cnt}, 64'd0);
`endif
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    hz_bus.i_id_rs1 = 5'd0;  hz_bus.i_id_rs2 = 5'd0;
    hz_bus.i_id_use_rs1 = 1'b0; hz_bus.i_id_use_rs2 = 1'b0;
    hz_bus.i_ex_rd = 5'd0; hz_bus.i_ex_is_load = 1'b0;
    hz_bus.i_ex_mdu_start = 1'b0; hz_bus.i_mdu_done = 1'b0;
    hz_bus.i_mem_req = 1'b0; hz_bus.i_mem_ready = 1'b0; hz_bus.i_ex_redirect = 1'b0;
  endtask

  initial begin
    bit mdu_lvl;
    i_rst = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    step();
    step();
    i_rst = 1'b0;

    // Load-use on x5 through rs1: one stall cycle, then clear.
    hz_bus.i_ex_is_load = 1'b1; hz_bus.i_ex_rd = 5'd5;
    hz_bus.i_id_rs1 = 5'd5; hz_bus.i_id_use_rs1 = 1'b1;
    #1 check_val("t1_stall_if", {63'd0, hz_bus.o_stall_if}, 64'd1);
    check_val("t1_bubble_ex", {63'd0, hz_bus.o_bubble_ex}, 64'd1);
    step();
    idle_inputs();
    step();

    // Load to x0, and rs2 match with use_rs2 clear: no stall.
    hz_bus.i_ex_is_load = 1'b1; hz_bus.i_ex_rd = 5'd0;
    hz_bus.i_id_rs1 = 5'd0; hz_bus.i_id_use_rs1 = 1'b1;
    step();
    hz_bus.i_ex_rd = 5'd7; hz_bus.i_id_rs1 = 5'd1; hz_bus.i_id_rs2 = 5'd7; hz_bus.i_id_use_rs2 = 1'b0;
    step();
    idle_inputs();

    // MDU op completing after four stalled cycles.
    hz_bus.i_ex_mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) step();
    hz_bus.i_mdu_done = 1'b1;
    #1 check_val("t3_done_release", {63'd0, hz_bus.o_stall_ex}, 64'd0);
    step();
    idle_inputs();
    step();

    // Memory wait during an MDU op, done pulsing inside the wait.
    hz_bus.i_ex_mdu_start = 1'b1;
    step(); step();
    hz_bus.i_mem_req = 1'b1; hz_bus.i_mem_ready = 1'b0;
    step();
    hz_bus.i_mdu_done = 1'b1;
    step();
    hz_bus.i_mdu_done = 1'b0;
    step();
    hz_bus.i_mem_ready = 1'b1;
    step();
    idle_inputs();
    step();

    // Redirect together with a load-use match: flush wins, no stall.
    hz_bus.i_ex_redirect = 1'b1; hz_bus.i_ex_is_load = 1'b1; hz_bus.i_ex_rd = 5'd3;
    hz_bus.i_id_rs2 = 5'd3; hz_bus.i_id_use_rs2 = 1'b1;
    #1 check_val("t5_flush", {63'd0, hz_bus.o_flush_if_id}, 64'd1);
    check_val("t5_no_stall", {63'd0, hz_bus.o_stall_if}, 64'd0);
    step();
    idle_inputs();

    // MDU that never completes: watchdog fires, stalls release, reset clears.
    hz_bus.i_ex_mdu_start = 1'b1;
    for (int i = 0; i < MDU_TO + 1; i++) step();
    check_val("t6_err_set", {63'd0, hz_bus.o_err}, 64'd1);
    hz_bus.i_ex_mdu_start = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_val("t6_err_cleared", {63'd0, hz_bus.o_err}, 64'd0);

    // Randomized traffic.
    mdu_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      i_rst = ($urandom_range(0, 199) == 0);
      hz_bus.i_id_rs1      = 5'($urandom_range(0, 3));
      hz_bus.i_id_rs2      = 5'($urandom_range(0, 3));
      hz_bus.i_id_use_rs1  = 1'($urandom_range(0, 1));
      hz_bus.i_id_use_rs2  = 1'($urandom_range(0, 1));
      hz_bus.i_ex_rd       = 5'($urandom_range(0, 3));
      hz_bus.i_ex_is_load  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) mdu_lvl = ~mdu_lvl;
      hz_bus.i_ex_mdu_start = mdu_lvl;
      hz_bus.i_mdu_done    = ($urandom_range(0, 5) == 0);
      hz_bus.i_mem_req     = ($urandom_range(0, 3) == 0);
      hz_bus.i_mem_ready   = 1'($urandom_range(0, 1));
      hz_bus.i_ex_redirect = ($urandom_range(0, 6) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
